multi_dir_light_ctrl: RTL and testbench
=======================================

# multi_dir_light_ctrl

Parametrised N-direction intersection controller: the next generation of the two-road North/East light controller. It serves `NUM_DIRS` approaches, one green at a time, with programmable green, yellow and all-red clearance durations. Sensor requests are latched, so single-cycle pulses are never lost. Conflicts are arbitrated round-robin. It sits between the vehicle-sensor front end and the lamp drivers, and exposes `state`, `active_dir` and `counter` for debug and testbench observation.

## Interface
- `NUM_DIRS`, 4, number of approaches (≥2)
- `GREEN_CYCLES`, 30, minimum green duration in clk cycles (≥1)
- `YELLOW_CYCLES`, 6, yellow duration (≥1)
- `ALLRED_CYCLES`, 2, all-red clearance duration (≥1)
- `CNT_W`, 5, counter width; must hold max(duration)−1
- `DIR_W`, $clog2(NUM_DIRS), width of direction index (derived)

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high; when high at a posedge, all registers load reset values
- `sensor`  in  NUM_DIRS  per-direction vehicle request, level or pulse, sampled each posedge
- `red`  out  NUM_DIRS  active-high red lamp per direction
- `yellow`  out  NUM_DIRS  active-high yellow lamp per direction
- `green`  out  NUM_DIRS  active-high green lamp per direction
- `state`  out  2  FSM state: 0 GREEN, 1 HOLD, 2 YELLOW, 3 ALLRED
- `active_dir`  out  DIR_W  direction currently owning green/yellow
- `counter`  out  CNT_W  in-state cycle counter

## Operation
- Reset values:
  - `state`=GREEN, `active_dir`=0, `counter`=0, `pending`=0, `target`=0.
  - Lamps: `green`[0]=1, all other `red`=1.
- Request latch:
  - `pending_next = (pending | sensor) & ~clr`.
  - `clr` is the one-hot of `target` on the cycle ALLRED exits to GREEN.
  - `req = (pending | sensor) & ~onehot(active_dir)`. A same-cycle sensor counts toward `req`.
  - The active direction's own requests are ignored for switching.
- Round-robin pick: first set bit of `req` scanning `active_dir+1`, `+2`, … with wrap modulo `NUM_DIRS`.
- GREEN:
  - `counter` increments each cycle.
  - At `counter==GREEN_CYCLES-1`: `counter`←0. If `req`≠0 → YELLOW and `target`←pick; else → HOLD.
- HOLD:
  - Green stays on; `counter` stays 0.
  - On the first cycle `req`≠0 → YELLOW, `target`←pick.
- YELLOW:
  - `counter` counts to `YELLOW_CYCLES-1`, then `counter`←0 → ALLRED.
  - `target` is frozen; later sensor activity does not change it.
- ALLRED:
  - `counter` counts to `ALLRED_CYCLES-1`, then `counter`←0, `active_dir`←`target` → GREEN. `pending[target]` is cleared.
- Lamp decode (combinational from registered `state` and `active_dir`; exactly one lamp per direction is high):
  - GREEN/HOLD: `green[active_dir]`=1.
  - YELLOW: `yellow[active_dir]`=1.
  - ALLRED: every direction red.
  - All non-active directions are always red.
- Width rules:
  - `counter` never exceeds max(duration)−1.
  - Direction increment wraps modulo `NUM_DIRS`, which need not be a power of two.
- Reset mid-operation (any state): next cycle is the full reset image. Pending requests are discarded.

## Timing
- State and counter update on posedge `clk`. Lamps follow the registered state with zero added latency.
- GREEN lasts exactly `GREEN_CYCLES` cycles when a request is waiting. HOLD adds ≥1 cycle otherwise.
- Switch latency from HOLD: sensor high in cycle t → YELLOW in cycle t+1.
- Full handover: YELLOW_CYCLES + ALLRED_CYCLES cycles with no green anywhere (8 at defaults).
- A sensor pulse of one cycle, in any state, is latched and eventually served.
- If a sensor pulse arrives on the same edge as `clr` for that direction, the pulse is consumed by that grant.
- Defaults, with a request present from reset release (cycle 0):
  - GREEN: cycles 0–29.
  - YELLOW: cycles 30–35.
  - ALLRED: cycles 36–37.
  - New GREEN from cycle 38.

## Test plan
- Reset check: hold `reset` 3 cycles, `sensor`=0. Require `state`=0, `active_dir`=0, `counter`=0, `green`=0001, `red`=1110, `yellow`=0000.
- Idle hold: no sensors for 100 cycles → `state` enters HOLD (1) at cycle 30 and stays. Then `sensor`=0100 at cycle 100 → YELLOW at 101, ALLRED at 107, GREEN with `active_dir`=2 at 109.
- Pulse latch: 1-cycle `sensor`=0010 at cycle 5 → `active_dir`=1 green at cycle 38. `pending`[1] is cleared, and no further switch occurs without new requests.
- Round-robin with wrap: all sensors held 1111 → green order 0,1,2,3,0. Each green lasts 30 cycles, and each handover has 8 lamp-no-green cycles.
- Wrap pick: `active_dir`=3 with requests on 0 and 2 → `target`=0. A request from the active dir 3 alone → no switch, stays in HOLD.
- Reset mid-YELLOW: assert `reset` during YELLOW with `pending`=1010 → next cycle shows the reset image. With no further sensors, the controller stays green on dir 0 and enters HOLD after 30 cycles.

Source files
------------

// File: rtl/multi_dir_light_ctrl.sv
// N-direction intersection light controller.
// Latched requests with round-robin green arbitration.
module multi_dir_light_ctrl #(
  parameter int NUM_DIRS      = 4,
  parameter int GREEN_CYCLES  = 30,
  parameter int YELLOW_CYCLES = 6,
  parameter int ALLRED_CYCLES = 2,
  parameter int CNT_W         = 5,
  parameter int DIR_W         = $clog2(NUM_DIRS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_DIRS-1:0] sensor,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] green,
  output logic [1:0]          state,
  output logic [DIR_W-1:0]    active_dir,
  output logic [CNT_W-1:0]    counter
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_HOLD   = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYCLES - 1);

  state_e              state_q, state_d;
  logic [DIR_W-1:0]    dir_q, dir_d;
  logic [DIR_W-1:0]    tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_DIRS-1:0] pend_q, pend_d;

  logic [NUM_DIRS-1:0] seen, act_oh, req, clr;
  logic [DIR_W-1:0]    pick;
  logic                found;
  int                  idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_GREEN;
      dir_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Descending scan so the nearest direction after the owner wins.
  always_comb begin
    seen   = pend_q | sensor;
    act_oh = NUM_DIRS'(1) << dir_q;
    req    = seen & ~act_oh;
    found  = 1'b0;
    pick   = '0;
    idx    = 0;
    for (int k = NUM_DIRS - 1; k >= 1; k--) begin
      idx = (int'(dir_q) + k) % NUM_DIRS;
      if (req[idx]) begin
        found = 1'b1;
        pick  = DIR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    clr     = '0;
    unique case (state_q)
      S_GREEN: begin
        if (cnt_q == G_LAST) begin
          cnt_d = '0;
          if (found) begin
            state_d = S_YELLOW;
            tgt_d   = pick;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (found) begin
          state_d = S_YELLOW;
          tgt_d   = pick;
        end
      end
      S_YELLOW: begin
        if (cnt_q == Y_LAST) begin
          cnt_d   = '0;
          state_d = S_ALLRED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ALLRED: begin
        if (cnt_q == A_LAST) begin
          cnt_d   = '0;
          dir_d   = tgt_q;
          state_d = S_GREEN;
          clr     = NUM_DIRS'(1) << tgt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_GREEN;
    endcase
    pend_d = seen & ~clr;
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    if (state_q == S_GREEN || state_q == S_HOLD)
      green = NUM_DIRS'(1) << dir_q;
    if (state_q == S_YELLOW)
      yellow = NUM_DIRS'(1) << dir_q;
    red = ~(green | yellow);
  end

  assign state      = state_q;
  assign active_dir = dir_q;
  assign counter    = cnt_q;

endmodule

// File: tb/tb_multi_dir_light_ctrl.sv
// Bench for multi_dir_light_ctrl: directed vector table
// plus randomized traffic against a timeline model.
module tb_multi_dir_light_ctrl;
  localparam int N = 4;
  localparam int G = 30;
  localparam int Y = 6;
  localparam int A = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sensor = '0;
  logic [3:0] red, yellow, green;
  logic [1:0] state;
  logic [1:0] active_dir;
  logic [4:0] counter;

  multi_dir_light_ctrl dut (
    .clk(clk), .reset(reset), .sensor(sensor),
    .red(red), .yellow(yellow), .green(green),
    .state(state), .active_dir(active_dir),
    .counter(counter)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 green, 1 hold, 2 yellow, 3 allred
  int m_ph = 0, m_dir = 0, m_cnt = 0, m_tgt = 0;
  bit m_pend[N];

  typedef struct {
    logic       rst;
    logic [3:0] sens;
    int         n;
    logic [1:0] st;
    logic [1:0] dir;
    logic [4:0] cnt;
    logic [3:0] g;
    logic [3:0] y;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] s, int n,
      logic [1:0] st, logic [1:0] d, logic [4:0] c,
      logic [3:0] g, logic [3:0] y);
    vec_t v;
    v.rst = r; v.sens = s; v.n = n; v.st = st;
    v.dir = d; v.cnt = c; v.g = g; v.y = y;
    return v;
  endfunction

  function automatic int dur(int ph);
    case (ph)
      0: return G;
      2: return Y;
      3: return A;
      default: return 0;
    endcase
  endfunction

  function automatic logic [20:0] pack(logic [1:0] st, logic [1:0] d,
      logic [4:0] c, logic [3:0] g, logic [3:0] y, logic [3:0] r);
    return {st, d, c, g, y, r};
  endfunction

  function automatic logic [20:0] dut_sig();
    return pack(state, active_dir, counter, green, yellow, red);
  endfunction

  function automatic logic [20:0] model_sig();
    logic [3:0] g, y;
    g = (m_ph <= 1) ? 4'(1) << m_dir : 4'b0;
    y = (m_ph == 2) ? 4'(1) << m_dir : 4'b0;
    return pack(2'(m_ph), 2'(m_dir), 5'(m_cnt), g, y, ~(g | y));
  endfunction

  task automatic model_step(input bit r, input logic [3:0] s);
    bit seen[N];
    int pick;
    int clr;
    pick = -1;
    clr = -1;
    if (r) begin
      m_ph = 0; m_dir = 0; m_cnt = 0; m_tgt = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      return;
    end
    foreach (seen[i]) seen[i] = m_pend[i] | s[i];
    for (int k = N - 1; k >= 1; k--)
      if (seen[(m_dir + k) % N]) pick = (m_dir + k) % N;
    if (m_ph == 1) begin
      if (pick >= 0) begin
        m_ph = 2;
        m_tgt = pick;
      end
    end else if (m_cnt < dur(m_ph) - 1) begin
      m_cnt++;
    end else begin
      m_cnt = 0;
      case (m_ph)
        0: if (pick >= 0) begin m_ph = 2; m_tgt = pick; end
           else m_ph = 1;
        2: m_ph = 3;
        default: begin m_ph = 0; m_dir = m_tgt; clr = m_tgt; end
      endcase
    end
    foreach (m_pend[i]) m_pend[i] = seen[i] && (i != clr);
  endtask

  task automatic check(input string name, input logic [20:0] act,
      input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] s);
    reset = r;
    sensor = s;
    @(posedge clk);
    model_step(r, s);
    #1;
    check("model", dut_sig(), model_sig());
  endtask

  initial begin
    // idle hold, then switch to dir 2
    tbl.push_back(mk(1, 4'b0000,  3, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 30, 1, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 70, 1, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0100,  1, 2, 0,  0, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0000,  6, 3, 0,  0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000,  2, 0, 2,  0, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 30, 1, 2,  0, 4'b0100, 4'b0000));
    // single-cycle pulse latch
    tbl.push_back(mk(1, 4'b0000,  1, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000,  5, 0, 0,  5, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0010,  1, 0, 0,  6, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 24, 2, 0,  0, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0000,  8, 0, 1,  0, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 30, 1, 1,  0, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 20, 1, 1,  0, 4'b0010, 4'b0000));
    // wrap pick from dir 3
    tbl.push_back(mk(1, 4'b0000,  1, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b1000,  1, 0, 0,  1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 37, 0, 3,  0, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 4'b0101,  1, 0, 3,  1, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 29, 2, 3,  0, 4'b0000, 4'b1000));
    tbl.push_back(mk(0, 4'b0000,  8, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 30, 2, 0,  0, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0000,  8, 0, 2,  0, 4'b0100, 4'b0000));
    // own request only: stays in hold
    tbl.push_back(mk(1, 4'b0000,  1, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b1000,  1, 0, 0,  1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 67, 1, 3,  0, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 4'b1000,  5, 1, 3,  0, 4'b1000, 4'b0000));
    // round robin, all sensors held
    tbl.push_back(mk(1, 4'b0000,  1, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 30, 2, 0,  0, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b1111,  8, 0, 1,  0, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 30, 2, 1,  0, 4'b0000, 4'b0010));
    tbl.push_back(mk(0, 4'b1111,  8, 0, 2,  0, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 38, 0, 3,  0, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 38, 0, 0,  0, 4'b0001, 4'b0000));
    // reset mid-yellow drops pending
    tbl.push_back(mk(1, 4'b0000,  1, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b1010, 30, 2, 0,  0, 4'b0000, 4'b0001));
    tbl.push_back(mk(1, 4'b0000,  1, 0, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 29, 0, 0, 29, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000,  1, 1, 0,  0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 20, 1, 0,  0, 4'b0001, 4'b0000));

    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc(tbl[i].rst, tbl[i].sens);
      check($sformatf("vec%0d", i), dut_sig(),
            pack(tbl[i].st, tbl[i].dir, tbl[i].cnt, tbl[i].g,
                 tbl[i].y, ~(tbl[i].g | tbl[i].y)));
    end

    // random sparse pulses with rare resets
    for (int c = 0; c < 5000; c++) begin
      logic [3:0] s;
      logic       r;
      for (int b = 0; b < N; b++) s[b] = ($urandom_range(23) == 0);
      r = ($urandom_range(599) == 0);
      cyc(r, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
